dffram_arbiter: RTL and testbench

//  Two-requester round-robin arbiter/sequencer for the 256x16 DFFRAM macro (dffram256x16_wrap).

---
 rtl/dffram_arbiter.sv | 137 +++++++++++++
 tb/tb_dffram_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dffram_arbiter.sv
// dffram_arbiter: two-requester round-robin sequencer sharing one 256x16 DFFRAM macro.
// Optional build macro DFFRAM_ARB_CLEAR_EN: zero-fill the whole RAM after every reset before serving.
module dffram_arbiter #(
    parameter int AW    = 8,
    parameter int WSIZE = 2
) (
    input  logic               clk_i,
    input  logic               rst_i,
    // Handshake: a request is accepted on a rising edge where pN_valid_i & pN_ready_o; the
    // requester holds we/addr/wdata stable while valid is high and ready is low.
    input  logic               p0_valid_i,
    output logic               p0_ready_o,
    input  logic [WSIZE-1:0]   p0_we_i,
    input  logic [AW-1:0]      p0_addr_i,
    input  logic [WSIZE*8-1:0] p0_wdata_i,
    output logic               p0_rvalid_o,
    output logic [WSIZE*8-1:0] p0_rdata_o,
    input  logic               p1_valid_i,
    output logic               p1_ready_o,
    input  logic [WSIZE-1:0]   p1_we_i,
    input  logic [AW-1:0]      p1_addr_i,
    input  logic [WSIZE*8-1:0] p1_wdata_i,
    output logic               p1_rvalid_o,
    output logic [WSIZE*8-1:0] p1_rdata_o,
    output logic               ram_en_o,
    output logic [WSIZE-1:0]   ram_we_o,
    output logic [AW-1:0]      ram_a_o,
    output logic [WSIZE*8-1:0] ram_di_o,
    input  logic [WSIZE*8-1:0] ram_do_i,
    output logic               init_done_o,
    output logic [1:0]         dbg_state
);

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_SERVE = 2'd1
    } state_t;

    state_t state;
    logic   last_grant;
    logic   rd_pend;
    logic   rd_port;
    logic   serving;
    logic   gnt0;
    logic   gnt1;

`ifdef DFFRAM_ARB_CLEAR_EN
    logic [AW-1:0] clr_cnt;
`endif

    assign serving = (state == ST_SERVE) && !rst_i;

    // On a tie the port that did not win last time is granted (last_grant=1 favours p0).
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (serving) begin
            if (p0_valid_i && p1_valid_i) begin
                gnt0 = last_grant;
                gnt1 = !last_grant;
            end else begin
                gnt0 = p0_valid_i;
                gnt1 = p1_valid_i;
            end
        end
    end

    always_comb begin
        ram_en_o = 1'b0;
        ram_we_o = '0;
        ram_a_o  = '0;
        ram_di_o = '0;
        if (gnt0) begin
            ram_en_o = 1'b1;
            ram_we_o = p0_we_i;
            ram_a_o  = p0_addr_i;
            ram_di_o = p0_wdata_i;
        end else if (gnt1) begin
            ram_en_o = 1'b1;
            ram_we_o = p1_we_i;
            ram_a_o  = p1_addr_i;
            ram_di_o = p1_wdata_i;
        end
`ifdef DFFRAM_ARB_CLEAR_EN
        else if ((state == ST_CLEAR) && !rst_i) begin
            ram_en_o = 1'b1;
            ram_we_o = '1;
            ram_a_o  = clr_cnt;
        end
`endif
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_grant <= 1'b1;
            rd_pend    <= 1'b0;
            rd_port    <= 1'b0;
`ifdef DFFRAM_ARB_CLEAR_EN
            clr_cnt    <= '0;
            state      <= ST_CLEAR;
`else
            state      <= ST_SERVE;
`endif
        end else begin
            rd_pend <= 1'b0;
            case (state)
`ifdef DFFRAM_ARB_CLEAR_EN
                ST_CLEAR: begin
                    clr_cnt <= clr_cnt + 1'b1;
                    if (clr_cnt == {AW{1'b1}}) begin
                        state <= ST_SERVE;
                    end
                end
`endif
                ST_SERVE: begin
                    if (gnt0 || gnt1) begin
                        last_grant <= gnt1;
                        rd_port    <= gnt1;
                        rd_pend    <= gnt0 ? (p0_we_i == '0) : (p1_we_i == '0);
                    end
                end
                default: state <= ST_SERVE;
            endcase
        end
    end

    // A response still in flight when reset arrives is dropped, hence the rst_i gating.
    assign p0_rvalid_o = rd_pend && !rd_port && !rst_i;
    assign p1_rvalid_o = rd_pend && rd_port && !rst_i;
    assign p0_rdata_o  = p0_rvalid_o ? ram_do_i : '0;
    assign p1_rdata_o  = p1_rvalid_o ? ram_do_i : '0;
    assign p0_ready_o  = gnt0;
    assign p1_ready_o  = gnt1;
    assign init_done_o = serving;
    assign dbg_state   = state;

endmodule

// File: tb/tb_dffram_arbiter.sv
// tb_dffram_arbiter: grant table, directed multi-cycle sequences and randomized traffic
// against a transaction-level model (memory array + response queue) of the arbiter.
module tb_dffram_arbiter;

    localparam int AW = 8;
    localparam int WSIZE = 2;
`ifdef DFFRAM_ARB_CLEAR_EN
    localparam int CLR_CYCLES = 256;
`else
    localparam int CLR_CYCLES = 0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic        v0, v1;
    logic [1:0]  we0, we1;
    logic [7:0]  a0, a1;
    logic [15:0] d0, d1;
    logic        r0, r1, rv0, rv1;
    logic [15:0] rd0, rd1;
    logic        ram_en;
    logic [1:0]  ram_we;
    logic [7:0]  ram_a;
    logic [15:0] ram_di, ram_do;
    logic        init_done;
    logic [1:0]  dbg_state;

    dffram_arbiter #(.AW(AW), .WSIZE(WSIZE)) dut (
        .clk_i(clk), .rst_i(rst),
        .p0_valid_i(v0), .p0_ready_o(r0), .p0_we_i(we0), .p0_addr_i(a0), .p0_wdata_i(d0),
        .p0_rvalid_o(rv0), .p0_rdata_o(rd0),
        .p1_valid_i(v1), .p1_ready_o(r1), .p1_we_i(we1), .p1_addr_i(a1), .p1_wdata_i(d1),
        .p1_rvalid_o(rv1), .p1_rdata_o(rd1),
        .ram_en_o(ram_en), .ram_we_o(ram_we), .ram_a_o(ram_a), .ram_di_o(ram_di),
        .ram_do_i(ram_do), .init_done_o(init_done), .dbg_state(dbg_state)
    );

    // Behavioural DFFRAM macro: byte-masked write, registered read data.
    logic [15:0] ram [256];
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we[0]) ram[ram_a][7:0] <= ram_di[7:0];
            if (ram_we[1]) ram[ram_a][15:8] <= ram_di[15:8];
            if (ram_we == 2'b00) ram_do <= ram[ram_a];
        end
    end

    // ---------------- scoreboard ----------------
    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        else n_pass++;
    endtask

    // Reference model: memory contents, who won the last contested tie, and read responses owed.
    logic [15:0] ref_mem [256];
    logic [16:0] exp_q[$];
    int m_last = 1;
    int clr_left = 0;

    task automatic apply_req(input int port, input logic [1:0] we, input logic [7:0] a,
                             input logic [15:0] d);
        if (we == 2'b00) begin
            exp_q.push_back({port[0], ref_mem[a]});
        end else begin
            if (we[0]) ref_mem[a][7:0] = d[7:0];
            if (we[1]) ref_mem[a][15:8] = d[15:8];
        end
    endtask

    task automatic step();
        logic        g0, g1, e_ok;
        logic [16:0] e;
        if (rst) begin
            chk("rst_ready0", r0, 0);
            chk("rst_ready1", r1, 0);
            chk("rst_ram_en", ram_en, 0);
            chk("rst_ram_we", ram_we, 0);
            chk("rst_rvalid0", rv0, 0);
            chk("rst_rvalid1", rv1, 0);
            chk("rst_init_done", init_done, 0);
            exp_q.delete();
            m_last = 1;
            clr_left = CLR_CYCLES;
            return;
        end
        e_ok = exp_q.size() > 0;
        e = e_ok ? exp_q.pop_front() : 17'd0;
        chk("rvalid0", rv0, e_ok && !e[16]);
        chk("rvalid1", rv1, e_ok && e[16]);
        chk("rdata0", rd0, (e_ok && !e[16]) ? e[15:0] : 16'h0);
        chk("rdata1", rd1, (e_ok && e[16]) ? e[15:0] : 16'h0);
        if (clr_left > 0) begin
            chk("clr_init_done", init_done, 0);
            chk("clr_ready0", r0, 0);
            chk("clr_ready1", r1, 0);
            chk("clr_ram_en", ram_en, 1);
            chk("clr_ram_we", ram_we, 2'b11);
            chk("clr_ram_a", ram_a, 256 - clr_left);
            chk("clr_ram_di", ram_di, 0);
            ref_mem[256 - clr_left] = 16'h0;
            clr_left--;
            return;
        end
        chk("init_done", init_done, 1);
        g0 = v0 && (!v1 || m_last == 1);
        g1 = v1 && !g0;
        chk("ready0", r0, g0);
        chk("ready1", r1, g1);
        chk("ram_en", ram_en, g0 || g1);
        if (g0) begin
            chk("ram_we_p0", ram_we, we0);
            chk("ram_a_p0", ram_a, a0);
            chk("ram_di_p0", ram_di, d0);
            apply_req(0, we0, a0, d0);
            m_last = 0;
        end else if (g1) begin
            chk("ram_we_p1", ram_we, we1);
            chk("ram_a_p1", ram_a, a1);
            chk("ram_di_p1", ram_di, d1);
            apply_req(1, we1, a1, d1);
            m_last = 1;
        end else begin
            chk("idle_ram_we", ram_we, 0);
        end
    endtask

    always @(negedge clk) step();

    // ---------------- driver tasks ----------------
    task automatic idle_inputs();
        v0 = 0; v1 = 0; we0 = 0; we1 = 0; a0 = 0; a1 = 0; d0 = 0; d1 = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        @(negedge clk);
        @(posedge clk); #1;
        rst = 0;
    endtask

    task automatic wait_init(input string name);
        int n = 0;
        while (n < 400) begin
            @(negedge clk);
            if (init_done) break;
            n++;
            @(posedge clk); #1;
        end
        chk(name, n, CLR_CYCLES);
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic       v0, v1;
        logic [7:0] a0, a1;
        logic       r0, r1;
    } vec_t;
    vec_t vt[9];

    int prev_g;
    logic acc0, acc1;
    int wait0, wait1;

    initial begin
        // Grant sequence from reset (p0 wins the first tie), all reads.
        vt[0] = '{1, 1, 8'h01, 8'h02, 1, 0};
        vt[1] = '{1, 1, 8'h03, 8'h04, 0, 1};
        vt[2] = '{0, 1, 8'h05, 8'h06, 0, 1};
        vt[3] = '{1, 1, 8'h07, 8'h08, 1, 0};
        vt[4] = '{0, 0, 8'h09, 8'h0a, 0, 0};
        vt[5] = '{1, 1, 8'h0b, 8'h0c, 0, 1};
        vt[6] = '{1, 0, 8'h0d, 8'h0e, 1, 0};
        vt[7] = '{1, 0, 8'h0f, 8'h10, 1, 0};
        vt[8] = '{1, 1, 8'h11, 8'h12, 0, 1};

        idle_inputs();
        rst = 1;
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
        rst = 0;
        wait_init("init_after_power_on");

        for (int i = 0; i < 9; i++) begin
            v0 = vt[i].v0; v1 = vt[i].v1; a0 = vt[i].a0; a1 = vt[i].a1; we0 = 0; we1 = 0;
            @(negedge clk);
            chk($sformatf("vec%0d_ready0", i), r0, vt[i].r0);
            chk($sformatf("vec%0d_ready1", i), r1, vt[i].r1);
            @(posedge clk); #1;
        end
        idle_inputs();

        // p0 fills memory with data=addr, then p1 reads everything back.
        for (int i = 0; i < 256; i++) begin
            v0 = 1; we0 = 2'b11; a0 = 8'(i); d0 = 16'(i);
            @(negedge clk);
            @(posedge clk); #1;
        end
        idle_inputs();
        for (int i = 0; i <= 256; i++) begin
            v1 = (i < 256); a1 = 8'(i);
            @(negedge clk);
            if (i > 0) begin
                chk("fill_rvalid1", rv1, 1);
                chk("fill_rdata1", rd1, 16'(i - 1));
            end
            @(posedge clk); #1;
        end
        idle_inputs();

        // Continuous contention: grants alternate, responses land on the right port.
        prev_g = -1;
        for (int i = 0; i < 21; i++) begin
            v0 = (i < 20); v1 = (i < 20); a0 = 8'h03; a1 = 8'h07;
            @(negedge clk);
            if (prev_g == 0) chk("alt_rdata0", rd0, 16'h0003);
            if (prev_g == 1) chk("alt_rdata1", rd1, 16'h0007);
            if (i < 20) begin
                chk("alt_one_grant", r0 ^ r1, 1);
                if (prev_g >= 0) chk("alt_switch", r1, prev_g == 0);
                prev_g = r1 ? 1 : 0;
            end
            @(posedge clk); #1;
        end
        idle_inputs();

        // Byte-masked write merges with existing data.
        v0 = 1; we0 = 2'b11; a0 = 8'h10; d0 = 16'hAAAA;
        @(negedge clk); @(posedge clk); #1;
        we0 = 2'b01; d0 = 16'h1234;
        @(negedge clk); @(posedge clk); #1;
        we0 = 2'b00;
        @(negedge clk); @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
        chk("merge_rvalid0", rv0, 1);
        chk("merge_rdata0", rd0, 16'hAA34);
        @(posedge clk); #1;

        // Reset right after a read grant: the response is dropped, p0 wins the first tie after.
        v0 = 1; we0 = 0; a0 = 8'h10;
        @(negedge clk);
        chk("pre_rst_ready0", r0, 1);
        @(posedge clk); #1;
        rst = 1; v0 = 1; v1 = 1;
        @(negedge clk);
        chk("drop_rvalid0", rv0, 0);
        chk("drop_ready0", r0, 0);
        chk("drop_ram_en", ram_en, 0);
        @(posedge clk); #1;
        rst = 0; idle_inputs();
        wait_init("init_after_rst4");
        v0 = 1; v1 = 1; a0 = 8'h20; a1 = 8'h21;
        @(negedge clk);
        chk("post_rst_tie_p0", r0, 1);
        chk("post_rst_tie_p1", r1, 0);
        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk); @(posedge clk); #1;

`ifdef DFFRAM_ARB_CLEAR_EN
        v0 = 1; we0 = 2'b11; a0 = 8'h42; d0 = 16'hBEEF;
        @(negedge clk); @(posedge clk); #1;
        do_reset();
        wait_init("clear_len");
        v0 = 1; we0 = 0; a0 = 8'h42;
        @(negedge clk); @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
        chk("cleared_rdata0", rd0, 16'h0000);
        @(posedge clk); #1;
        do_reset();
        v0 = 1; v1 = 1;
        repeat (100) begin @(negedge clk); @(posedge clk); #1; end
        do_reset();
        wait_init("clear_restart_len");
`endif

        // Randomized traffic with requesters that hold their request until accepted.
        acc0 = 0; acc1 = 0; wait0 = 0; wait1 = 0;
        for (int i = 0; i < 600; i++) begin
            if (!v0 || acc0) begin
                v0 = $urandom_range(0, 3) != 0;
                we0 = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
                a0 = 8'($urandom_range(0, 15));
                d0 = 16'($urandom);
            end
            if (!v1 || acc1) begin
                v1 = $urandom_range(0, 3) != 0;
                we1 = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
                a1 = 8'($urandom_range(0, 15));
                d1 = 16'($urandom);
            end
            @(negedge clk);
            acc0 = v0 && r0;
            acc1 = v1 && r1;
            wait0 = (v0 && !r0) ? wait0 + 1 : 0;
            wait1 = (v1 && !r1) ? wait1 + 1 : 0;
            chk("max_wait0", wait0 <= 1, 1);
            chk("max_wait1", wait1 <= 1, 1);
            @(posedge clk); #1;
        end
        idle_inputs();
        repeat (3) begin @(negedge clk); @(posedge clk); #1; end
        chk("resp_queue_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
